// File: rtl/window_feature_extractor_pkg.sv
// Shared types, constants and the square-root digit step for the window feature extractor.
package window_feature_extractor_pkg;

  localparam int WIN_LOG2   = 6;
  localparam int SAMPLE_W   = 16;
  localparam int SQRT_ITERS = 16;
  localparam int FEAT_W     = 32;
  localparam int ROOT_W     = FEAT_W / 2;
  localparam int REM_W      = ROOT_W + 2;

  typedef enum logic [2:0] {
    ST_ACCUM = 3'd0,
    ST_MEAN  = 3'd1,
    ST_VAR   = 3'd2,
    ST_SQRT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic [REM_W-1:0]  rem;
    logic [ROOT_W-1:0] root;
  } sqrt_step_t;

  // One restoring digit step: bring down a bit pair, try (root<<2)|1 against the remainder.
  function automatic sqrt_step_t isqrt_step(input logic [REM_W-1:0] rem,
                                            input logic [ROOT_W-1:0] root,
                                            input logic [1:0] pair);
    logic [REM_W+1:0] shifted;
    logic [REM_W+1:0] trial;
    sqrt_step_t       res;
    shifted = {rem, pair};
    trial   = {2'b00, root, 2'b01};
    if (shifted >= trial) begin
      res.rem  = REM_W'(shifted - trial);
      res.root = {root[ROOT_W-2:0], 1'b1};
    end else begin
      res.rem  = shifted[REM_W-1:0];
      res.root = {root[ROOT_W-2:0], 1'b0};
    end
    return res;
  endfunction

endpackage

// File: rtl/window_feature_extractor_isqrt.sv
// Bit-serial integer square root: one result bit per cycle, the first resolved on the start edge.
module isqrt_seq
  import window_feature_extractor_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [FEAT_W-1:0] radicand,
  output logic [ROOT_W-1:0] root,
  output logic              done
);

  localparam int CNT_W = $clog2(SQRT_ITERS + 1);

  logic [FEAT_W-1:0] x_r;
  logic [REM_W-1:0]  rem_r;
  logic [ROOT_W-1:0] root_r;
  logic [CNT_W-1:0]  iter_r;
  logic              busy_r;
  logic              done_r;
  sqrt_step_t        first_s;
  sqrt_step_t        next_s;

  assign first_s = isqrt_step({REM_W{1'b0}}, {ROOT_W{1'b0}}, radicand[FEAT_W-1:FEAT_W-2]);
  assign next_s  = isqrt_step(rem_r, root_r, x_r[FEAT_W-1:FEAT_W-2]);

  // Iteration state and registered done pulse after the last digit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_r    <= {FEAT_W{1'b0}};
      rem_r  <= {REM_W{1'b0}};
      root_r <= {ROOT_W{1'b0}};
      iter_r <= {CNT_W{1'b0}};
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else if (start) begin
      x_r    <= {radicand[FEAT_W-3:0], 2'b00};
      rem_r  <= first_s.rem;
      root_r <= first_s.root;
      iter_r <= CNT_W'(SQRT_ITERS - 1);
      busy_r <= 1'b1;
      done_r <= 1'b0;
    end else if (busy_r) begin
      x_r    <= {x_r[FEAT_W-3:0], 2'b00};
      rem_r  <= next_s.rem;
      root_r <= next_s.root;
      iter_r <= iter_r - CNT_W'(1);
      busy_r <= (iter_r != CNT_W'(1));
      done_r <= (iter_r == CNT_W'(1));
    end else begin
      done_r <= 1'b0;
    end
  end

  assign root = root_r;
  assign done = done_r;

endmodule

// File: rtl/window_feature_extractor.sv
// Non-overlapping window mean / standard deviation over 2^WIN_LOG2 signed samples.
module window_feature_extractor
  import window_feature_extractor_pkg::*;
#(
  parameter int WIN_LOG2 = window_feature_extractor_pkg::WIN_LOG2,
  parameter int SAMPLE_W = window_feature_extractor_pkg::SAMPLE_W
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       sample_valid,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  output logic                       sample_ready,
  output logic        [FEAT_W-1:0]   feature_mean,
  output logic        [FEAT_W-1:0]   feature_std,
  output logic                       feat_valid,
  output logic                       overrun
);

  localparam int SUM_W   = SAMPLE_W + WIN_LOG2;
  localparam int SUMSQ_W = 2 * SAMPLE_W - 2 + WIN_LOG2 + 1;
  localparam int SQ_W    = 2 * SAMPLE_W;
  localparam int DIFF_W  = FEAT_W + 1;

  state_t                      state_r;
  logic                        ready_r;
  logic [WIN_LOG2-1:0]         cnt_r;
  logic signed [SUM_W-1:0]     sum_r;
  logic [SUMSQ_W-1:0]          sumsq_r;
  logic signed [SAMPLE_W-1:0]  mean_r;
  logic [FEAT_W-1:0]           var_r;
  logic                        sqrt_start_r;
  logic [FEAT_W-1:0]           feature_mean_r;
  logic [FEAT_W-1:0]           feature_std_r;
  logic                        feat_valid_r;
  logic                        overrun_r;

  logic signed [SQ_W-1:0]      sq_s;
  logic signed [SQ_W-1:0]      msq_s;
  logic signed [DIFF_W-1:0]    diff_s;
  logic [FEAT_W-1:0]           var_s;
  logic [ROOT_W-1:0]           sqrt_root_s;
  logic                        sqrt_done_s;

  assign sq_s  = sample_in * sample_in;
  assign msq_s = mean_r * mean_r;

  // Variance from the mean square minus squared floor-mean; rounding can dip below zero.
  always_comb begin
    diff_s = $signed({{(DIFF_W - (SUMSQ_W - WIN_LOG2)){1'b0}}, sumsq_r[SUMSQ_W-1:WIN_LOG2]})
           - $signed({{(DIFF_W - SQ_W){msq_s[SQ_W-1]}}, msq_s});
    if (diff_s[DIFF_W-1]) begin
      var_s = {FEAT_W{1'b0}};
    end else begin
      var_s = diff_s[FEAT_W-1:0];
    end
  end

  isqrt_seq u_isqrt (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (sqrt_start_r),
    .radicand (var_r),
    .root     (sqrt_root_s),
    .done     (sqrt_done_s)
  );

  // Window sequencer: accumulate, reduce, launch the root, publish features.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= ST_ACCUM;
      ready_r        <= 1'b1;
      cnt_r          <= {WIN_LOG2{1'b0}};
      sum_r          <= {SUM_W{1'b0}};
      sumsq_r        <= {SUMSQ_W{1'b0}};
      mean_r         <= {SAMPLE_W{1'b0}};
      var_r          <= {FEAT_W{1'b0}};
      sqrt_start_r   <= 1'b0;
      feature_mean_r <= {FEAT_W{1'b0}};
      feature_std_r  <= {FEAT_W{1'b0}};
      feat_valid_r   <= 1'b0;
      overrun_r      <= 1'b0;
    end else begin
      feat_valid_r <= 1'b0;
      sqrt_start_r <= 1'b0;
      if (sample_valid && !ready_r) begin
        overrun_r <= 1'b1;
      end
      case (state_r)
        ST_ACCUM: begin
          if (sample_valid) begin
            sum_r   <= sum_r + {{WIN_LOG2{sample_in[SAMPLE_W-1]}}, sample_in};
            sumsq_r <= sumsq_r + {{(SUMSQ_W - SQ_W){1'b0}}, sq_s};
            cnt_r   <= cnt_r + WIN_LOG2'(1);
            if (cnt_r == {WIN_LOG2{1'b1}}) begin
              state_r <= ST_MEAN;
              ready_r <= 1'b0;
            end
          end
        end
        ST_MEAN: begin
          // Dropping the low WIN_LOG2 bits of a two's-complement sum floors toward -inf.
          mean_r  <= sum_r[SUM_W-1:WIN_LOG2];
          state_r <= ST_VAR;
        end
        ST_VAR: begin
          var_r        <= var_s;
          sqrt_start_r <= 1'b1;
          state_r      <= ST_SQRT;
        end
        ST_SQRT: begin
          if (sqrt_done_s) begin
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          feature_mean_r <= {{(FEAT_W - SAMPLE_W){mean_r[SAMPLE_W-1]}}, mean_r};
          feature_std_r  <= {{(FEAT_W - ROOT_W){1'b0}}, sqrt_root_s};
          feat_valid_r   <= 1'b1;
          cnt_r          <= {WIN_LOG2{1'b0}};
          sum_r          <= {SUM_W{1'b0}};
          sumsq_r        <= {SUMSQ_W{1'b0}};
          state_r        <= ST_ACCUM;
          ready_r        <= 1'b1;
        end
        default: begin
          state_r <= ST_ACCUM;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign sample_ready = ready_r;
  assign feature_mean = feature_mean_r;
  assign feature_std  = feature_std_r;
  assign feat_valid   = feat_valid_r;
  assign overrun      = overrun_r;

endmodule

// File: tb/tb_window_feature_extractor.sv
// Directed bench for window_feature_extractor with hand-computed window features.
module tb_window_feature_extractor;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               sample_valid;
  logic signed [15:0] sample_in;
  logic               sample_ready;
  logic [31:0]        feature_mean;
  logic [31:0]        feature_std;
  logic               feat_valid;
  logic               overrun;

  int errors = 0;
  int checks = 0;
  logic early_feat;

  always #5 clk = ~clk;

  window_feature_extractor dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .sample_ready (sample_ready),
    .feature_mean (feature_mean),
    .feature_std  (feature_std),
    .feat_valid   (feat_valid),
    .overrun      (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic send(input int v);
    sample_valid = 1'b1;
    sample_in    = 16'(v);
    @(posedge clk);
    #1;
    if (feat_valid) early_feat = 1'b1;
  endtask

  task automatic send_n(input int n, input int v);
    for (int i = 0; i < n; i++) send(v);
  endtask

  task automatic wait_feat(input string tag, input logic [31:0] em, input logic [31:0] es);
    int k;
    k = 0;
    chk({tag, "_ready_low"}, {31'd0, sample_ready}, 32'd0);
    while (!feat_valid && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    sample_valid = 1'b0;
    chk({tag, "_latency"}, k, 32'd20);
    chk({tag, "_mean"}, feature_mean, em);
    chk({tag, "_std"}, feature_std, es);
    @(posedge clk);
    #1;
    chk({tag, "_pulse_one"}, {31'd0, feat_valid}, 32'd0);
    chk({tag, "_ready_back"}, {31'd0, sample_ready}, 32'd1);
  endtask

  initial begin
    reset_n      = 1'b0;
    sample_valid = 1'b0;
    sample_in    = 16'sd0;
    early_feat   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, sample_ready}, 32'd1);
    chk("rst_fv", {31'd0, feat_valid}, 32'd0);
    chk("rst_mean", feature_mean, 32'd0);
    chk("rst_std", feature_std, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    send_n(64, 1000);
    sample_valid = 1'b0;
    wait_feat("const1000", 32'd1000, 32'd0);
    chk("const1000_ovr", {31'd0, overrun}, 32'd0);

    for (int i = 0; i < 64; i++) send((i % 2 == 0) ? 300 : -300);
    sample_valid = 1'b0;
    wait_feat("alt300", 32'd0, 32'd300);

    for (int i = 0; i < 64; i++) send(i);
    sample_valid = 1'b0;
    wait_feat("ramp", 32'd31, 32'd19);

    send_n(64, -32768);
    sample_valid = 1'b0;
    wait_feat("minval", 32'hFFFF8000, 32'd0);

    // Floor mean of -1/64 is -1, so the raw variance is -1 and must clamp.
    send_n(63, 0);
    send(-1);
    sample_valid = 1'b0;
    wait_feat("clamp", 32'hFFFFFFFF, 32'd0);
    chk("clamp_ovr", {31'd0, overrun}, 32'd0);

    send_n(64, 7);
    sample_valid = 1'b1;
    sample_in    = 16'sd9999;
    wait_feat("busy_hold", 32'd7, 32'd0);
    chk("ovr_set", {31'd0, overrun}, 32'd1);
    send_n(10, -5);
    chk("hold_mean", feature_mean, 32'd7);
    send_n(54, -5);
    sample_valid = 1'b0;
    wait_feat("after_ovr", 32'hFFFFFFFB, 32'd0);
    chk("ovr_sticky", {31'd0, overrun}, 32'd1);

    send_n(40, 123);
    sample_valid = 1'b0;
    reset_n = 1'b0;
    #2;
    chk("midwin_rst_ovr", {31'd0, overrun}, 32'd0);
    chk("midwin_rst_mean", feature_mean, 32'd0);
    chk("midwin_rst_ready", {31'd0, sample_ready}, 32'd1);
    @(posedge clk);
    #1;
    reset_n    = 1'b1;
    early_feat = 1'b0;
    send_n(64, 500);
    sample_valid = 1'b0;
    chk("midwin_no_early", {31'd0, early_feat}, 32'd0);
    wait_feat("midwin", 32'd500, 32'd0);

    send_n(64, 50);
    sample_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #2;
    chk("midsqrt_rst_std", feature_std, 32'd0);
    @(posedge clk);
    #1;
    reset_n    = 1'b1;
    early_feat = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (feat_valid) early_feat = 1'b1;
    end
    chk("midsqrt_discard", {31'd0, early_feat}, 32'd0);
    send_n(64, 2);
    sample_valid = 1'b0;
    wait_feat("after_sqrt_rst", 32'd2, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
